bomb_game_ctrl: RTL and testbench



---
 rtl/bomb_pkg.sv | 16 +
 rtl/btn_pulse.sv | 36 +++
 rtl/bomb_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_bomb_game_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Shared definitions for the bomb-defusal game: game state encoding (also
// decoded by the seven-segment display stage) and the legal countdown range.
package bomb_pkg;

   typedef enum logic [1:0] {
      ST_SETUP  = 2'd0,
      ST_ARMED  = 2'd1,
      ST_DEFUSE = 2'd2,
      ST_OVER   = 2'd3
   } game_st_t;

   localparam int CDTIME_MIN = 1;
   localparam int CDTIME_MAX = 30;
   localparam int LT_W       = 5;

endpackage

// File: rtl/btn_pulse.sv
// Raw button conditioner: two-flop synchroniser followed by a rising-edge
// detector. Emits a registered one-cycle pulse three clk edges after the raw
// input rises; holding the button yields exactly one pulse.
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   btn   - raw, asynchronous button level
//   pulse - one-cycle pulse per press
module btn_pulse (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic pulse
);

   logic sync_1;
   logic sync_2;
   logic sync_2_d;
   logic pulse_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         sync_2_d <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         sync_1   <= btn;
         sync_2   <= sync_1;
         sync_2_d <= sync_2;
         pulse_q  <= sync_2 & ~sync_2_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/bomb_game_ctrl.sv
// Bomb-defusal game controller: game FSM, one-second countdown tick and the
// user-configured countdown time.
//   clk, rst_n           - system clock, asynchronous active-low reset
//   sw7                  - game power switch (0 = off, forces SETUP)
//   btn_start/up/down/confirm - raw player buttons, synchronised here
//   code_in              - defuse code switches
//   game_state           - current state, see table below
//   leave_times          - remaining seconds + 1 (display shows value-1)
//   user_defined_cdtime  - configured countdown, 1..30
//   exploded, defused    - mutually exclusive result flags
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_SETUP  | idle; up/down adjust countdown, start arms the bomb
// ST_ARMED  | counting down; start enters defuse entry
// ST_DEFUSE | counting down; confirm checks code_in
// ST_OVER   | result shown; start returns to setup
module bomb_game_ctrl
   import bomb_pkg::*;
#(
   parameter int         TICK_DIV       = 100000000,
   parameter int         DEFAULT_CDTIME = 10,
   parameter logic [3:0] SECRET         = 4'b1011,
   parameter int         PENALTY        = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            sw7,
   input  logic            btn_start,
   input  logic            btn_up,
   input  logic            btn_down,
   input  logic            btn_confirm,
   input  logic [3:0]      code_in,
   output logic [1:0]      game_state,
   output logic [LT_W-1:0] leave_times,
   output logic [LT_W-1:0] user_defined_cdtime,
   output logic            exploded,
   output logic            defused
);

   localparam int                CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic start_p, up_p, down_p, confirm_p;

   btn_pulse u_start   (.clk(clk), .rst_n(rst_n), .btn(btn_start),   .pulse(start_p));
   btn_pulse u_up      (.clk(clk), .rst_n(rst_n), .btn(btn_up),      .pulse(up_p));
   btn_pulse u_down    (.clk(clk), .rst_n(rst_n), .btn(btn_down),    .pulse(down_p));
   btn_pulse u_confirm (.clk(clk), .rst_n(rst_n), .btn(btn_confirm), .pulse(confirm_p));

   game_st_t        state_q, state_d;
   logic [LT_W-1:0] lt_q, lt_d;
   logic [LT_W-1:0] cd_q, cd_d;
   logic            exp_q, exp_d;
   logic            def_q, def_d;
   logic [CNT_W-1:0] cnt_q;
   logic            cnt_clr;
   logic            running;
   logic            tick;
   logic [5:0]      pen_amt;

   assign running = (state_q == ST_ARMED) || (state_q == ST_DEFUSE);
   assign tick    = running && (cnt_q == CNT_LAST);

   // Tick counter keeps its phase across ARMED<->DEFUSE moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!sw7 || cnt_clr) begin
         cnt_q <= '0;
      end else if (running) begin
         cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SETUP;
         lt_q    <= '0;
         cd_q    <= LT_W'(DEFAULT_CDTIME);
         exp_q   <= 1'b0;
         def_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lt_q    <= lt_d;
         cd_q    <= cd_d;
         exp_q   <= exp_d;
         def_q   <= def_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lt_d    = lt_q;
      cd_d    = cd_q;
      exp_d   = exp_q;
      def_d   = def_q;
      cnt_clr = 1'b0;
      // A wrong code costs one extra second when it lands on a tick.
      pen_amt = 6'(PENALTY) + {5'd0, tick};

      if (!sw7) begin
         state_d = ST_SETUP;
         lt_d    = '0;
         exp_d   = 1'b0;
         def_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_SETUP: begin
               if (start_p) begin
                  lt_d    = cd_q + LT_W'(1);
                  exp_d   = 1'b0;
                  def_d   = 1'b0;
                  cnt_clr = 1'b1;
                  state_d = ST_ARMED;
               end else if (up_p && !down_p && cd_q < LT_W'(CDTIME_MAX)) begin
                  cd_d = cd_q + LT_W'(1);
               end else if (down_p && !up_p && cd_q > LT_W'(CDTIME_MIN)) begin
                  cd_d = cd_q - LT_W'(1);
               end
            end
            ST_ARMED: begin
               if (tick && lt_q <= LT_W'(1)) begin
                  lt_d    = '0;
                  exp_d   = 1'b1;
                  state_d = ST_OVER;
               end else begin
                  if (tick) lt_d = lt_q - LT_W'(1);
                  if (start_p) state_d = ST_DEFUSE;
               end
            end
            ST_DEFUSE: begin
               if (confirm_p && code_in == SECRET) begin
                  def_d   = 1'b1;
                  state_d = ST_OVER;
               end else if (confirm_p) begin
                  if ({1'b0, lt_q} <= pen_amt + 6'd1) begin
                     lt_d    = '0;
                     exp_d   = 1'b1;
                     state_d = ST_OVER;
                  end else begin
                     lt_d    = lt_q - pen_amt[LT_W-1:0];
                     state_d = ST_ARMED;
                  end
               end else if (tick && lt_q <= LT_W'(1)) begin
                  lt_d    = '0;
                  exp_d   = 1'b1;
                  state_d = ST_OVER;
               end else if (tick) begin
                  lt_d = lt_q - LT_W'(1);
               end
            end
            ST_OVER: begin
               if (start_p) begin
                  lt_d    = '0;
                  exp_d   = 1'b0;
                  def_d   = 1'b0;
                  state_d = ST_SETUP;
               end
            end
            default: state_d = ST_SETUP;
         endcase
      end
   end

   always_comb begin
      game_state          = state_q;
      leave_times         = lt_q;
      user_defined_cdtime = cd_q;
      exploded            = exp_q;
      defused             = def_q;
   end

endmodule

// File: tb/tb_bomb_game_ctrl.sv
module tb_bomb_game_ctrl;

   localparam int         TD     = 4;
   localparam logic [3:0] SECRET = 4'b1011;
   localparam int         PEN    = 5;
   localparam int         DEF_CD = 10;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sw7;
   logic       btn_start, btn_up, btn_down, btn_confirm;
   logic [3:0] code_in;
   logic [1:0] game_state;
   logic [4:0] leave_times, user_defined_cdtime;
   logic       exploded, defused;

   int checks = 0;
   int errors = 0;

   bomb_game_ctrl #(.TICK_DIV(TD), .DEFAULT_CDTIME(DEF_CD), .SECRET(SECRET), .PENALTY(PEN)) dut (
      .clk(clk), .rst_n(rst_n), .sw7(sw7),
      .btn_start(btn_start), .btn_up(btn_up), .btn_down(btn_down), .btn_confirm(btn_confirm),
      .code_in(code_in), .game_state(game_state), .leave_times(leave_times),
      .user_defined_cdtime(user_defined_cdtime), .exploded(exploded), .defused(defused)
   );

   always #5 clk = ~clk;

   // Reference model: game rules in plain integers. A press is seen by the
   // game three edges after the edge that first samples it high.
   int m_state, m_lt, m_cd, m_exp, m_def, m_cnt;
   logic [4:0] h_st, h_up, h_dn, h_cf;

   task automatic model_reset();
      m_state = 0; m_lt = 0; m_cd = DEF_CD; m_exp = 0; m_def = 0; m_cnt = 0;
      h_st = '0; h_up = '0; h_dn = '0; h_cf = '0;
   endtask

   task automatic model_step();
      bit ps, pu, pd, pc, tk, live;
      int nc, d;
      if (!rst_n) begin
         model_reset();
         return;
      end
      h_st = {h_st[3:0], btn_start};
      h_up = {h_up[3:0], btn_up};
      h_dn = {h_dn[3:0], btn_down};
      h_cf = {h_cf[3:0], btn_confirm};
      ps = h_st[3] & ~h_st[4];
      pu = h_up[3] & ~h_up[4];
      pd = h_dn[3] & ~h_dn[4];
      pc = h_cf[3] & ~h_cf[4];
      live = (m_state == 1) || (m_state == 2);
      tk = live && (m_cnt == TD - 1);
      nc = live ? (m_cnt + 1) % TD : m_cnt;
      if (!sw7) begin
         m_state = 0; m_lt = 0; m_exp = 0; m_def = 0; nc = 0;
      end else if (m_state == 0) begin
         if (ps) begin
            m_lt = m_cd + 1; m_exp = 0; m_def = 0; m_state = 1; nc = 0;
         end else if (pu && !pd) m_cd = (m_cd >= 30) ? 30 : m_cd + 1;
         else if (pd && !pu) m_cd = (m_cd <= 1) ? 1 : m_cd - 1;
      end else if (m_state == 1) begin
         if (tk) begin
            if (m_lt == 1) begin m_lt = 0; m_exp = 1; m_state = 3; end
            else m_lt = m_lt - 1;
         end
         if (ps && m_state == 1) m_state = 2;
      end else if (m_state == 2) begin
         if (pc && code_in == SECRET) begin
            m_def = 1; m_state = 3;
         end else if (pc) begin
            d = PEN + (tk ? 1 : 0);
            if (m_lt <= d + 1) begin m_lt = 0; m_exp = 1; m_state = 3; end
            else begin m_lt = m_lt - d; m_state = 1; end
         end else if (tk) begin
            if (m_lt == 1) begin m_lt = 0; m_exp = 1; m_state = 3; end
            else m_lt = m_lt - 1;
         end
      end else begin
         if (ps) begin m_state = 0; m_lt = 0; m_exp = 0; m_def = 0; end
      end
      m_cnt = nc;
   endtask

   task automatic cmp(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_model();
      cmp("model state", int'(game_state), m_state);
      cmp("model leave_times", int'(leave_times), m_lt);
      cmp("model cdtime", int'(user_defined_cdtime), m_cd);
      cmp("model exploded", int'(exploded), m_exp);
      cmp("model defused", int'(defused), m_def);
      cmp("flags exclusive", int'(exploded & defused), 0);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic clr_btn();
      btn_start = 0; btn_up = 0; btn_down = 0; btn_confirm = 0;
   endtask

   typedef struct {
      bit sw, st, up, dn, cf;
      logic [3:0] code;
      int reps, pre;
      int e_state, e_lt, e_cd, e_exp, e_def;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input bit sw, st, up, dn, cf, input logic [3:0] code,
                               input int reps, pre, es, el, ec, ee, ed);
      vec_t v;
      v.sw = sw; v.st = st; v.up = up; v.dn = dn; v.cf = cf; v.code = code;
      v.reps = reps; v.pre = pre;
      v.e_state = es; v.e_lt = el; v.e_cd = ec; v.e_exp = ee; v.e_def = ed;
      tbl.push_back(v);
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      for (int r = 0; r < v.reps; r++) begin
         sw7 = v.sw; code_in = v.code; clr_btn();
         for (int p = 0; p < v.pre; p++) cyc();
         btn_start = v.st; btn_up = v.up; btn_down = v.dn; btn_confirm = v.cf;
         cyc();
         clr_btn();
         repeat (3) cyc();
      end
      cmp($sformatf("vec%0d state", idx), int'(game_state), v.e_state);
      cmp($sformatf("vec%0d leave_times", idx), int'(leave_times), v.e_lt);
      cmp($sformatf("vec%0d cdtime", idx), int'(user_defined_cdtime), v.e_cd);
      cmp($sformatf("vec%0d exploded", idx), int'(exploded), v.e_exp);
      cmp($sformatf("vec%0d defused", idx), int'(defused), v.e_def);
   endtask

   initial begin
      //  sw st up dn cf code   reps pre  state lt cd exp def
      add(1, 0, 1, 0, 0, 4'd0,    25, 0,  0,  0, 30, 0, 0);
      add(1, 0, 0, 1, 0, 4'd0,    40, 0,  0,  0,  1, 0, 0);
      add(1, 0, 1, 0, 0, 4'd0,     2, 0,  0,  0,  3, 0, 0);
      add(1, 0, 1, 1, 0, 4'd0,     1, 0,  0,  0,  3, 0, 0);
      add(1, 0, 0, 1, 0, 4'd0,     1, 0,  0,  0,  2, 0, 0);
      add(1, 0, 1, 0, 0, 4'd0,     1, 0,  0,  0,  3, 0, 0);
      add(1, 1, 1, 0, 0, 4'd0,     1, 0,  1,  4,  3, 0, 0);
      add(1, 0, 0, 0, 0, 4'd0,     1, 0,  1,  3,  3, 0, 0);
      add(1, 0, 0, 0, 0, 4'd0,     1, 0,  1,  2,  3, 0, 0);
      add(1, 0, 0, 0, 0, 4'd0,     1, 0,  1,  1,  3, 0, 0);
      add(1, 0, 0, 0, 0, 4'd0,     1, 0,  3,  0,  3, 1, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  0,  0,  3, 0, 0);
      add(1, 0, 1, 0, 0, 4'd0,     7, 0,  0,  0, 10, 0, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  1, 11, 10, 0, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  2, 10, 10, 0, 0);
      add(1, 0, 0, 0, 1, SECRET,   1, 0,  3, 10, 10, 0, 1);
      add(1, 0, 0, 0, 0, 4'd0,     1, 0,  3, 10, 10, 0, 1);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  0,  0, 10, 0, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  1, 11, 10, 0, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  2, 10, 10, 0, 0);
      add(1, 0, 0, 0, 1, 4'd0,     1, 1,  1,  4, 10, 0, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  2,  3, 10, 0, 0);
      add(1, 0, 0, 0, 1, 4'd0,     1, 0,  3,  0, 10, 1, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  0,  0, 10, 0, 0);
      add(1, 0, 0, 1, 0, 4'd0,     9, 0,  0,  0,  1, 0, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  1,  2,  1, 0, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  2,  1,  1, 0, 0);
      add(1, 0, 0, 0, 1, SECRET,   1, 0,  3,  1,  1, 0, 1);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  0,  0,  1, 0, 0);
      add(1, 1, 0, 0, 0, 4'd0,     1, 0,  1,  2,  1, 0, 0);
      add(0, 0, 0, 0, 0, 4'd0,     1, 0,  0,  0,  1, 0, 0);
      add(0, 1, 0, 0, 0, 4'd0,     1, 0,  0,  0,  1, 0, 0);
      add(0, 0, 1, 0, 0, 4'd0,     1, 0,  0,  0,  1, 0, 0);
      add(1, 0, 1, 0, 0, 4'd0,     1, 0,  0,  0,  2, 0, 0);

      rst_n = 0; sw7 = 1; code_in = 0; clr_btn();
      model_reset();
      repeat (3) @(negedge clk);
      cmp("reset state", int'(game_state), 0);
      cmp("reset leave_times", int'(leave_times), 0);
      cmp("reset cdtime", int'(user_defined_cdtime), DEF_CD);
      cmp("reset flags", int'({exploded, defused}), 0);
      rst_n = 1;
      cyc();

      // Holding up for many cycles gives a single increment.
      btn_up = 1;
      repeat (10) cyc();
      btn_up = 0;
      repeat (2) cyc();
      cmp("hold one pulse cdtime", int'(user_defined_cdtime), DEF_CD + 1);

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // Arm, then pull reset between edges: outputs clear without a clock.
      btn_start = 1; cyc(); clr_btn(); repeat (5) cyc();
      cmp("pre-reset armed", int'(game_state), 1);
      #2;
      rst_n = 0;
      #1;
      cmp("async reset state", int'(game_state), 0);
      cmp("async reset leave_times", int'(leave_times), 0);
      cmp("async reset cdtime", int'(user_defined_cdtime), DEF_CD);
      cmp("async reset flags", int'({exploded, defused}), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      cyc();

      for (int i = 0; i < 4000; i++) begin
         sw7         = ($urandom_range(0, 99) != 0);
         btn_start   = ($urandom_range(0, 11) == 0);
         btn_up      = ($urandom_range(0, 5) == 0);
         btn_down    = ($urandom_range(0, 5) == 0);
         btn_confirm = ($urandom_range(0, 9) == 0);
         code_in     = ($urandom_range(0, 1) == 0) ? SECRET : 4'($urandom);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
